// File: rtl/bus_responder.sv
// bus_responder -- single-clock asynchronous-style bus slave with a small
// word memory, a programmable number of wait states and a one-cycle,
// registered active-low acknowledge.
//
// Handshake: the initiator drops AS_N together with WR_N/ADDR/DO and keeps
// AS_N low until it sees ACK_N low. The responder captures the request on
// the first edge it sees AS_N low. It then spends WAIT_CYCLES cycles in WAIT.
// After that it spends one cycle in ACK. ACK_N is low for the single cycle
// after ACK. The responder stays in HOLD until AS_N returns high, so one
// strobe yields exactly one ACK_N pulse. Raising AS_N during WAIT aborts the
// request.
//
// Parameters:
//   DEPTH_LOG2  : log2 of memory word count (ADDR[DEPTH_LOG2-1:0] is the index)
//   WAIT_CYCLES : wait states before ACK, 0..15
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   AS_N, WR_N       : address strobe, write qualifier (0 = store)
//   ADDR, DO         : word address, write data from initiator
//   DI               : read data, updated on entry to ACK for loads only
//   ACK_N            : registered active-low acknowledge
//   busy             : state is not IDLE
//   rd_cnt, wr_cnt   : completed load/store counters
//   dbg_state        : current FSM state (0 IDLE, 1 WAIT, 2 ACK, 3 HOLD)
//
// Optional feature: define BUS_RESPONDER_CNT_EN to implement rd_cnt/wr_cnt.
// Without it both outputs are tied to zero.
module bus_responder #(
  parameter int DEPTH_LOG2  = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AS_N,
  input  logic        WR_N,
  input  logic [31:0] ADDR,
  input  logic [31:0] DO,
  output logic [31:0] DI,
  output logic        ACK_N,
  output logic        busy,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  localparam int WORDS = 1 << DEPTH_LOG2;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             di_q, di_d;
  logic                    ack_n_q, ack_n_d;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [31:0]             rd_word;

  logic [31:0] mem [WORDS];

  // Upper address bits are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDR[31:DEPTH_LOG2];

  // With zero wait states the read happens on the capturing edge, so the
  // index comes straight from the bus instead of the capture register.
  assign rd_idx  = (state_q == S_IDLE) ? ADDR[DEPTH_LOG2-1:0] : idx_q;
  assign rd_word = mem[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    di_d    = di_q;
    // ACK_N is registered off the ACK state, so its low cycle trails ACK by one.
    ack_n_d = (state_q != S_ACK);
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!AS_N) begin
          idx_d   = ADDR[DEPTH_LOG2-1:0];
          wr_d    = !WR_N;
          wdata_d = DO;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
            cnt_d   = 4'd0;
            if (WR_N) di_d = rd_word;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (AS_N) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          cnt_d   = 4'd0;
          if (!wr_q) di_d = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        // Strobe release here does not cancel: the write commits on exit.
        state_d = S_HOLD;
        mem_we  = wr_q;
      end
      S_HOLD: begin
        if (AS_N) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      di_q    <= 32'd0;
      ack_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      di_q    <= di_d;
      ack_n_q <= ack_n_d;
    end
  end

  // Memory is never cleared; reset only blocks a write on the ACK-exit edge.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[idx_q] <= wdata_q;
  end

`ifdef BUS_RESPONDER_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == S_ACK) begin
      if (wr_q) wr_cnt_d = wr_cnt_q + 16'd1;
      else      rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 16'd0;
  assign wr_cnt = 16'd0;
`endif

  assign DI        = di_q;
  assign ACK_N     = ack_n_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 5: log2 of word count of internal memory (32 x 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before ACK_N, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 AS_N  input  1  active-low address strobe from bus initiator; held low until ACK_N seen.
REQ-006 WR_N  input  1  active-low write qualifier; 0 = store, 1 = load/fetch.
REQ-007 ADDR  input  32  word address; only ADDR[DEPTH_LOG2-1:0] used, upper bits ignored.
REQ-008 DO  input  32  write data from initiator.
REQ-009 DI  output  32  read data to initiator.
REQ-010 ACK_N  output  1  active-low acknowledge, registered.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 rd_cnt  output  16  completed-read counter (see Configuration).
REQ-013 wr_cnt  output  16  completed-write counter (see Configuration).

Function
REQ-014 FSM states: IDLE, WAIT, ACK, HOLD; encoding free, one-hot not required.
REQ-015 IDLE: at edge with AS_N=0, capture ADDR index, WR_N and DO into internal registers; load wait counter with WAIT_CYCLES; go WAIT (or ACK directly if WAIT_CYCLES=0).
REQ-016 WAIT: decrement counter each edge; go ACK when counter reaches 1 -> exactly WAIT_CYCLES cycles spent in WAIT.
REQ-017 Latency: ACK_N low in cycle beginning WAIT_CYCLES+1 edges after the capturing edge.
REQ-018 ACK: ACK_N=0 for exactly one cycle; then go HOLD.
REQ-019 Write: memory word at captured index updated with captured DO on the edge leaving ACK; later changes to DO/ADDR during the transaction have no effect.
REQ-020 Read: DI driven with memory[captured index] on the edge entering ACK; DI held stable until the next read's ACK; writes do not alter DI.
REQ-021 HOLD: stay while AS_N=0; go IDLE on edge with AS_N=1; no second ACK for one strobe assertion.
REQ-022 Abort: AS_N=1 sampled in WAIT -> go IDLE, no ACK, no memory write, counters unchanged.
REQ-023 AS_N=1 sampled in ACK state does not cancel the acknowledge or the write.
REQ-024 Write to same index as immediately following read returns the newly written data.
REQ-025 Memory contents uninitialised at power-up; never cleared by reset.

Reset
REQ-026 reset=1 at edge: state IDLE, ACK_N=1, busy=0, DI=0, wait counter=0, rd_cnt=wr_cnt=0.
REQ-027 Reset mid-transaction (WAIT/ACK/HOLD): transaction dropped, no memory write if reset coincides with ACK-exit edge.
REQ-028 reset has priority over all other inputs.

Configuration
REQ-029 Macro BUS_RESPONDER_CNT_EN defined: rd_cnt/wr_cnt increment by 1 on each edge leaving ACK for read/write respectively, wrapping 0xFFFF->0x0000.
REQ-030 Macro undefined: counters not implemented; rd_cnt and wr_cnt tied to 0; all other behaviour identical.

Verification
REQ-031 WAIT_CYCLES=2, store: AS_N=0, WR_N=0, ADDR=3, DO=0xDEADBEEF captured at edge k -> ACK_N=0 only during cycle k+3; then load ADDR=3 -> DI=0xDEADBEEF during ACK.
REQ-032 WAIT_CYCLES=0: load ADDR=7 captured at edge k -> ACK_N=0 during cycle k+1, busy=1 from k+1 until AS_N=1 returns FSM to IDLE.
REQ-033 AS_N held low 5 cycles after ACK -> exactly one ACK_N pulse, FSM stays HOLD, IDLE one edge after AS_N=1.
REQ-034 Abort: AS_N=0 store ADDR=1 DO=0x1, AS_N=1 during WAIT -> no ACK_N pulse, later load ADDR=1 returns prior contents, wr_cnt unchanged.
REQ-035 Reset asserted in WAIT -> next cycle ACK_N=1, busy=0, DI=0, counters=0; new transaction then completes normally.
REQ-036 With BUS_RESPONDER_CNT_EN: 3 loads + 2 stores -> rd_cnt=3, wr_cnt=2; preload 0xFFFF reached then one more read -> rd_cnt=0; without macro both read 0 throughout.
